// File: rtl/bdf_pkg.sv
// Shared types for the BDF schedule sequencer: FSM state encoding and schedule word sizing.
package bdf_pkg;

   typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_LAST} seq_state_t;

   localparam int BDF_NUM_BUFS = 12;
   localparam int BDF_WORD_W   = 2 * BDF_NUM_BUFS;

   function automatic int sched_word_w(input int num_bufs);
      return 2 * num_bufs;
   endfunction

endpackage

// File: rtl/sched_mem.sv
// Schedule store: simple dual-port RAM, synchronous write, registered read (1-cycle latency).
module sched_mem #(
   parameter  int WIDTH = 24,
   parameter  int DEPTH = 48,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q, rd_data_d;

   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem_q[rd_addr];
      end
   end

   // Array and read register are intentionally left unreset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
      rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/bdf_sched_seq.sv
// Replays a stored per-cycle toggle schedule onto the buffer bank for a programmable period,
// either N iterations or continuously until a graceful stop; first word appears two cycles after start.
module bdf_sched_seq
   import bdf_pkg::*;
#(
   parameter  int NUM_BUFS = BDF_NUM_BUFS,
   parameter  int DEPTH    = 48,
   parameter  int ITER_W   = 16,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_wr_en,
   input  logic [AW-1:0]         cfg_wr_addr,
   input  logic [2*NUM_BUFS-1:0] cfg_wr_data,
   input  logic [AW:0]           cfg_period,
   input  logic [ITER_W-1:0]     cfg_iters,
   input  logic                  start,
   input  logic                  stop,
   output logic                  busy,
   output logic                  done,
   output logic                  cfg_err,
   output logic [ITER_W-1:0]     iter_cnt,
   output logic                  buff_wr_toggle [NUM_BUFS],
   output logic                  buff_rd_toggle [NUM_BUFS]
);

   localparam int WORD_W = sched_word_w(NUM_BUFS);

   seq_state_t        state_q, state_d;
   logic [AW-1:0]     rd_addr_q, rd_addr_d;
   logic [AW-1:0]     last_addr_q, last_addr_d;
   logic [ITER_W-1:0] iters_q, iters_d;
   logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
   logic              stop_pend_q, stop_pend_d;
   logic              pres_vld_q, pres_vld_d;
   logic              cfg_err_q, cfg_err_d;

   logic              is_idle;
   logic              addr_ok;
   logic              period_ok;
   logic              mem_wr_en;
   logic              mem_rd_en;
   logic              rd_wrap;
   logic              final_iter;
   logic [WORD_W-1:0] rd_data;

   assign is_idle    = (state_q == SEQ_IDLE);
   assign addr_ok    = (32'(cfg_wr_addr) < DEPTH);
   assign period_ok  = (cfg_period != '0) && (32'(cfg_period) <= DEPTH);
   assign mem_wr_en  = cfg_wr_en && is_idle && addr_ok;
   assign rd_wrap    = (rd_addr_q == last_addr_q);
   // Current iteration is iter_cnt_q+1, so it is the last one when iter_cnt_q == iters-1.
   assign final_iter = (iters_q != '0) && (iter_cnt_q == (iters_q - ITER_W'(1)));

   always_comb begin
      state_d     = state_q;
      rd_addr_d   = rd_addr_q;
      last_addr_d = last_addr_q;
      iters_d     = iters_q;
      iter_cnt_d  = iter_cnt_q;
      stop_pend_d = stop_pend_q;
      mem_rd_en   = 1'b0;
      cfg_err_d   = (cfg_wr_en && !(is_idle && addr_ok)) || (is_idle && start && !period_ok);

      case (state_q)
         SEQ_IDLE: begin
            stop_pend_d = 1'b0;
            if (start && period_ok) begin
               state_d     = SEQ_RUN;
               rd_addr_d   = '0;
               iter_cnt_d  = '0;
               last_addr_d = AW'(cfg_period - 1'b1);
               iters_d     = cfg_iters;
            end
         end
         SEQ_RUN: begin
            mem_rd_en   = 1'b1;
            stop_pend_d = stop_pend_q | stop;
            rd_addr_d   = rd_wrap ? '0 : rd_addr_q + AW'(1);
            if (rd_wrap) begin
               // Counter lands together with the presentation of the wrap word.
               if (!(&iter_cnt_q)) begin
                  iter_cnt_d = iter_cnt_q + ITER_W'(1);
               end
               if (final_iter || stop_pend_q || stop) begin
                  state_d = SEQ_LAST;
               end
            end
         end
         SEQ_LAST: begin
            state_d     = SEQ_IDLE;
            stop_pend_d = 1'b0;
         end
         default: begin
            state_d = SEQ_IDLE;
         end
      endcase

      pres_vld_d = mem_rd_en;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= SEQ_IDLE;
         rd_addr_q   <= '0;
         last_addr_q <= '0;
         iters_q     <= '0;
         iter_cnt_q  <= '0;
         stop_pend_q <= 1'b0;
         pres_vld_q  <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         last_addr_q <= last_addr_d;
         iters_q     <= iters_d;
         iter_cnt_q  <= iter_cnt_d;
         stop_pend_q <= stop_pend_d;
         pres_vld_q  <= pres_vld_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   sched_mem #(
      .WIDTH (WORD_W),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (mem_wr_en),
      .wr_addr (cfg_wr_addr),
      .wr_data (cfg_wr_data),
      .rd_en   (mem_rd_en),
      .rd_addr (rd_addr_q),
      .rd_data (rd_data)
   );

   assign busy     = !is_idle;
   assign done     = (state_q == SEQ_LAST);
   assign cfg_err  = cfg_err_q;
   assign iter_cnt = iter_cnt_q;

   // The read register is unreset, so toggles are gated by whether a word was read last cycle.
   always_comb begin
      for (int k = 0; k < NUM_BUFS; k++) begin
         buff_wr_toggle[k] = pres_vld_q & rd_data[2*k];
         buff_rd_toggle[k] = pres_vld_q & rd_data[2*k+1];
      end
   end

endmodule

// File: tb/tb_bdf_sched_seq.sv
// Self-checking bench for bdf_sched_seq: directed scenarios plus randomized runs against an arithmetic model.
module tb_bdf_sched_seq;

   localparam int NB = 12;
   localparam int D  = 48;
   localparam int IW = 16;
   localparam int AW = 6;
   localparam int WW = 24;
   localparam longint BIG = 64'd1 << 40;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_wr_en = 1'b0;
   logic [AW-1:0] cfg_wr_addr = '0;
   logic [WW-1:0] cfg_wr_data = '0;
   logic [AW:0]   cfg_period = '0;
   logic [IW-1:0] cfg_iters = '0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          busy, done, cfg_err;
   logic [IW-1:0] iter_cnt;
   logic          buff_wr_toggle [NB];
   logic          buff_rd_toggle [NB];

   always #5 clk = ~clk;

   bdf_sched_seq dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
      .cfg_period(cfg_period), .cfg_iters(cfg_iters), .start(start), .stop(stop),
      .busy(busy), .done(done), .cfg_err(cfg_err), .iter_cnt(iter_cnt),
      .buff_wr_toggle(buff_wr_toggle), .buff_rd_toggle(buff_rd_toggle)
   );

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   // Model: a run is described by the cycle index n since entering RUN and the index of
   // the final presented word; everything else is arithmetic on those.
   logic [WW-1:0] mem_m [D];
   bit     m_active;
   longint m_n, m_pend, m_period, m_iter_idle;
   bit     m_err;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [WW-1:0] dut_word();
      logic [WW-1:0] w;
      for (int k = 0; k < NB; k++) begin
         w[2*k]   = buff_wr_toggle[k];
         w[2*k+1] = buff_rd_toggle[k];
      end
      return w;
   endfunction

   function automatic longint sat(input longint v);
      return (v > 65535) ? 65535 : v;
   endfunction

   function automatic logic [WW-1:0] exp_word();
      if (m_active && m_n >= 1) return mem_m[int'((m_n - 1) % m_period)];
      return '0;
   endfunction

   function automatic bit exp_done();
      return m_active && (m_n == m_pend + 1);
   endfunction

   function automatic longint exp_iter();
      return m_active ? sat(m_n / m_period) : m_iter_idle;
   endfunction

   task automatic model_reset();
      m_active = 1'b0; m_n = 0; m_pend = 0; m_period = 1; m_iter_idle = 0; m_err = 1'b0;
   endtask

   // Applies the inputs sampled at the clock edge that just occurred.
   task automatic model_edge();
      bit cur_busy;
      bit legal;
      longint lim;
      cur_busy = m_active;
      legal    = (cfg_period >= 1) && (cfg_period <= D);
      m_err    = (cfg_wr_en && (cur_busy || cfg_wr_addr >= D)) || (!cur_busy && start && !legal);
      if (!cur_busy) begin
         if (cfg_wr_en && cfg_wr_addr < D) mem_m[cfg_wr_addr] = cfg_wr_data;
         if (start && legal) begin
            m_active = 1'b1;
            m_n      = 0;
            m_period = longint'(cfg_period);
            m_pend   = (cfg_iters != 0) ? longint'(cfg_iters) * m_period - 1 : BIG;
         end
      end else begin
         if (stop && m_n <= m_pend) begin
            lim = (m_n / m_period + 1) * m_period - 1;
            if (lim < m_pend) m_pend = lim;
         end
         m_n++;
         if (m_n > m_pend + 1) begin
            m_active    = 1'b0;
            m_iter_idle = sat((m_pend + 1) / m_period);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_edge();
      start = 1'b0; stop = 1'b0; cfg_wr_en = 1'b0;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", 64'(busy), 64'(m_active));
         chk("done", 64'(done), 64'(exp_done()));
         chk("cfg_err", 64'(cfg_err), 64'(m_err));
         chk("iter_cnt", 64'(iter_cnt), 64'(exp_iter()));
         chk("toggles", 64'(dut_word()), 64'(exp_word()));
      end
   end

   task automatic write_word(input int addr, input logic [WW-1:0] data);
      cfg_wr_en = 1'b1; cfg_wr_addr = AW'(addr); cfg_wr_data = data;
      tick();
   endtask

   // Launches a run, optionally pulsing stop / a rejected write at given RUN-cycle indices.
   task automatic run(input int period, input int iters, input bit stop_w_start,
                      input int stop_at, input int wr_at, input int cap_at,
                      output int bc, output int dn, output logic [WW-1:0] cap);
      int k;
      cfg_period = (AW+1)'(period); cfg_iters = IW'(iters);
      start = 1'b1; stop = stop_w_start;
      tick();
      bc = 0; dn = 0; k = 0; cap = '0;
      while (busy && k < 2000) begin
         if (bc == stop_at) stop = 1'b1;
         if (bc == wr_at) begin
            cfg_wr_en = 1'b1; cfg_wr_addr = 6'd5; cfg_wr_data = ~mem_m[5];
         end
         if (bc == cap_at) cap = dut_word();
         if (done) dn++;
         tick();
         bc++; k++;
      end
      chk("run_ends_in_budget", 64'(k < 2000), 64'd1);
   endtask

   logic [WW-1:0] exp2 [8];
   logic [WW-1:0] cap, saved5;
   int bc, dn, k, r, per;

   initial begin
      exp2 = '{24'h1, 24'h2, 24'h4, 24'h8, 24'h1, 24'h2, 24'h4, 24'h8};
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_iter", 64'(iter_cnt), 64'd0);
      chk("reset_toggles", 64'(dut_word()), 64'd0);

      for (int a = 0; a < D; a++) write_word(a, WW'($urandom));
      write_word(0, 24'h1); write_word(1, 24'h2); write_word(2, 24'h4); write_word(3, 24'h8);

      // Period 4, two iterations: literal word stream and a single done on the last word.
      cfg_period = 7'd4; cfg_iters = 16'd2; start = 1'b1;
      tick();
      chk("t2_busy_first", 64'(busy), 64'd1);
      chk("t2_first_gated", 64'(dut_word()), 64'd0);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("t2_word", 64'(dut_word()), 64'(exp2[i]));
         chk("t2_done", 64'(done), 64'(i == 7));
      end
      chk("t2_iter", 64'(iter_cnt), 64'd2);
      tick();
      chk("t2_idle", 64'(busy), 64'd0);
      chk("t2_iter_hold", 64'(iter_cnt), 64'd2);

      // Continuous, stop while word 0 of iteration 5 is presented.
      run(3, 0, 1'b0, 13, -1, -1, bc, dn, cap);
      chk("t3_done_count", 64'(dn), 64'd1);
      chk("t3_busy_cycles", 64'(bc), 64'd16);
      chk("t3_iter", 64'(iter_cnt), 64'd5);

      // Illegal periods.
      cfg_period = 7'd0; start = 1'b1; tick();
      chk("t4_p0_err", 64'(cfg_err), 64'd1);
      chk("t4_p0_idle", 64'(busy), 64'd0);
      cfg_period = 7'd49; start = 1'b1; tick();
      chk("t4_p49_err", 64'(cfg_err), 64'd1);
      chk("t4_p49_idle", 64'(busy), 64'd0);
      write_word(50, 24'hABCDEF);
      chk("t4_badaddr_err", 64'(cfg_err), 64'd1);

      // Write while busy is rejected; read word 5 back through a full-depth run.
      saved5 = mem_m[5];
      run(D, 1, 1'b0, -1, 3, -1, bc, dn, cap);
      run(D, 1, 1'b0, -1, -1, 6, bc, dn, cap);
      chk("t4_readback", 64'(cap), 64'(saved5));

      run(1, 1, 1'b0, -1, -1, -1, bc, dn, cap);
      chk("t5_busy_cycles", 64'(bc), 64'd2);
      chk("t5_done_count", 64'(dn), 64'd1);

      run(2, 2, 1'b1, -1, -1, -1, bc, dn, cap);
      chk("t6_startstop_busy", 64'(bc), 64'd5);
      chk("t6_startstop_iter", 64'(iter_cnt), 64'd2);
      run(2, 1, 1'b0, 1, -1, -1, bc, dn, cap);
      chk("t6_coincident_busy", 64'(bc), 64'd3);
      chk("t6_coincident_done", 64'(dn), 64'd1);

      // Asynchronous reset mid-run.
      cfg_period = 7'd5; cfg_iters = 16'd3; start = 1'b1;
      tick();
      repeat (4) tick();
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("t1_rst_busy", 64'(busy), 64'd0);
      chk("t1_rst_toggles", 64'(dut_word()), 64'd0);
      chk("t1_rst_iter", 64'(iter_cnt), 64'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      dn = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done) dn++;
      end
      chk("t1_no_done", 64'(dn), 64'd0);

      // Randomized runs.
      for (int run_i = 0; run_i < 40; run_i++) begin
         repeat ($urandom_range(0, 3)) write_word(int'($urandom_range(0, 63)), WW'($urandom));
         r = int'($urandom_range(0, 9));
         if (r == 0)      per = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(49, 127));
         else if (r == 1) per = D;
         else             per = int'($urandom_range(1, 8));
         cfg_period = (AW+1)'(per);
         cfg_iters  = IW'($urandom_range(0, 3));
         start = 1'b1;
         stop  = ($urandom_range(0, 4) == 0);
         tick();
         k = 0;
         while (busy && k < 600) begin
            if ((cfg_iters == 0 && k >= 40) || $urandom_range(0, 19) == 0) stop = 1'b1;
            if ($urandom_range(0, 9) == 0) begin
               cfg_wr_en = 1'b1; cfg_wr_addr = AW'($urandom_range(0, 63)); cfg_wr_data = WW'($urandom);
            end
            if ($urandom_range(0, 14) == 0) begin
               start = 1'b1; cfg_period = (AW+1)'($urandom_range(0, 60));
            end
            tick();
            k++;
         end
         chk("rand_run_ends", 64'(k < 600), 64'd1);
         tick();
      end

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
